// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: state encoding,
// default watchdog limit and a small address helper.
package mem_stage_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HOLD = 2'd2
  } ms_state_t;

  localparam int DEF_TIMEOUT = 255;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;

  // A halfword access is misaligned when the byte-offset bit is set.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/dff.sv
// Generic W-bit register cell with synchronous active-high reset to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register the next value; reset clears to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_watchdog.sv
// Wait-cycle watchdog for the memory stage. The counter is cleared when a
// request is issued and advances once per WAIT cycle; o_expired flags the
// last WAIT cycle allowed before a timeout (counter == TIMEOUT-1).
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Count WAIT cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // After this WAIT cycle the counter would reach TIMEOUT.
  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage controller between EX/MEM and MEM/WB.
// Issues one request per load/store to a stalling data memory, freezes the
// pipeline until completion (or watchdog timeout), then releases it for one
// HOLD cycle with the load data and error flag presented.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd addresses with a
// one-cycle error and no memory request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] writeDataIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              validIn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memRd,
  output logic              memWr,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memDone,
  input  logic              memBusy,
  input  logic              memErrIn,
  output logic [DATA_W-1:0] memDataOut,
  output logic              stallOut,
  output logic              errOut
);

  logic [1:0]        r_state;
  logic              r_perr;
  logic              r_is_ld;
  logic [DATA_W-1:0] r_data;

  ms_state_t         w_state;
  ms_state_t         w_state_nxt;
  logic              w_perr_d;
  logic              w_is_ld_d;
  logic [DATA_W-1:0] w_data_d;
  logic              w_acc;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_bad;
  logic              w_rd;
  logic              w_wr;
  logic              w_stall;
  logic              w_err;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_expired;

  assign w_acc     = validIn & (MemReadIn | MemWriteIn);
  assign w_illegal = w_acc & MemReadIn & MemWriteIn;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_acc & is_misaligned(addrIn);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_bad   = w_illegal | w_misalign;
  assign w_state = ms_state_t'(r_state);

  // State, pending error, load-type flag and load data registers.
  dff #(.W(2))      u_state_ff (.clk(clk), .rst(rst), .d(w_state_nxt), .q(r_state));
  dff #(.W(1))      u_perr_ff  (.clk(clk), .rst(rst), .d(w_perr_d),    .q(r_perr));
  dff #(.W(1))      u_isld_ff  (.clk(clk), .rst(rst), .d(w_is_ld_d),   .q(r_is_ld));
  dff #(.W(DATA_W)) u_data_ff  (.clk(clk), .rst(rst), .d(w_data_d),    .q(r_data));

  mem_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  // Next-state, request, stall and error decode for IDLE/WAIT/HOLD.
  always_comb begin
    w_state_nxt = w_state;
    w_perr_d    = r_perr;
    w_is_ld_d   = r_is_ld;
    w_data_d    = r_data;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (w_state)
      MS_IDLE: begin
        if (w_bad) begin
          // Illegal or misaligned access: flag it and let the pipeline move on.
          w_err = 1'b1;
        end else if (w_acc) begin
          w_stall = 1'b1;
          if (!memBusy) begin
            w_rd        = MemReadIn;
            w_wr        = MemWriteIn;
            w_is_ld_d   = MemReadIn;
            w_perr_d    = 1'b0;
            w_cnt_clr   = 1'b1;
            w_state_nxt = MS_WAIT;
          end else begin
            w_state_nxt = MS_IDLE;
          end
        end else begin
          w_state_nxt = MS_IDLE;
        end
      end
      MS_WAIT: begin
        w_stall  = 1'b1;
        w_cnt_en = 1'b1;
        if (memDone) begin
          // Completion wins over a timeout in the same cycle.
          if (r_is_ld) begin
            w_data_d = memRData;
          end else begin
            w_data_d = r_data;
          end
          w_perr_d    = memErrIn;
          w_state_nxt = MS_HOLD;
        end else if (w_expired) begin
          w_perr_d    = 1'b1;
          w_state_nxt = MS_HOLD;
        end else begin
          w_state_nxt = MS_WAIT;
        end
      end
      MS_HOLD: begin
        w_err       = r_perr;
        w_perr_d    = 1'b0;
        w_state_nxt = MS_IDLE;
      end
      default: begin
        w_perr_d    = 1'b0;
        w_state_nxt = MS_IDLE;
      end
    endcase
  end

  assign memAddr    = addrIn;
  assign memWData   = writeDataIn;
  // Requests and error pulses are suppressed while reset is applied.
  assign memRd      = w_rd & ~rst;
  assign memWr      = w_wr & ~rst;
  assign errOut     = w_err & ~rst;
  assign stallOut   = w_stall;
  assign memDataOut = r_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (TIMEOUT=4). Directed steps from the test
// plan followed by randomized accesses checked against a transaction-level
// reference model (stall count, request count, error and load data).
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addrIn;
  logic [15:0] writeDataIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic        validIn;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memRd;
  logic        memWr;
  logic [15:0] memRData;
  logic        memDone;
  logic        memBusy;
  logic        memErrIn;
  logic [15:0] memDataOut;
  logic        stallOut;
  logic        errOut;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] model_data;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .addrIn(addrIn), .writeDataIn(writeDataIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .validIn(validIn),
    .memAddr(memAddr), .memWData(memWData), .memRd(memRd), .memWr(memWr),
    .memRData(memRData), .memDone(memDone), .memBusy(memBusy),
    .memErrIn(memErrIn), .memDataOut(memDataOut), .stallOut(stallOut),
    .errOut(errOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bubble / no-access cycles with stale memory responses thrown in.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      validIn    = 1'b0;
      MemReadIn  = 1'($urandom);
      MemWriteIn = 1'b0;
      memBusy    = 1'($urandom);
      memDone    = 1'($urandom);
      memErrIn   = 1'($urandom);
      memRData   = 16'($urandom);
      #1;
      check("idle_stall", stallOut, 0);
      check("idle_req", {memRd, memWr, errOut}, 0);
      check("idle_data", memDataOut, model_data);
      @(negedge clk);
    end
  endtask

  // One load/store held frozen until its HOLD cycle; lat=0 means no memDone.
  task automatic do_access(input bit ld, input logic [15:0] addr, input logic [15:0] wd,
                           input int busy, input int lat, input logic [15:0] rd, input bit merr);
    int cyc = 0;
    int issued_at = -1;
    int n_rd = 0, n_wr = 0, n_stall = 0, n_err = 0;
    bit got_hold = 1'b0;
    logic e_hold = 1'b0;
    logic [15:0] d_hold = 16'h0000;
    bit tmo;
    int eff;
    logic [15:0] exp_data;
    validIn = 1'b1; MemReadIn = ld; MemWriteIn = !ld; addrIn = addr; writeDataIn = wd;
    while (!got_hold && cyc < 64) begin
      if (issued_at < 0) begin
        memBusy = (cyc < busy);
        memDone = 1'($urandom);
      end else begin
        memBusy = 1'($urandom);
        memDone = (lat > 0) && ((cyc - issued_at) == lat);
      end
      memRData = (memDone && issued_at >= 0) ? rd : 16'($urandom);
      memErrIn = (memDone && issued_at >= 0) ? merr : 1'($urandom);
      #1;
      if (cyc == 0) begin
        check("mem_addr", memAddr, addr);
        check("mem_wdata", memWData, wd);
      end
      if (memRd) n_rd++;
      if (memWr) n_wr++;
      if ((memRd || memWr) && issued_at < 0) issued_at = cyc;
      if (errOut) n_err++;
      if (stallOut) n_stall++;
      else if (issued_at >= 0) begin
        got_hold = 1'b1; e_hold = errOut; d_hold = memDataOut;
      end
      @(negedge clk);
      cyc++;
    end
    tmo      = !(lat >= 1 && lat <= TO);
    eff      = tmo ? TO : lat;
    exp_data = (ld && !tmo) ? rd : model_data;
    check("hold_seen", got_hold, 1);
    check("issue_cycle", issued_at, busy);
    check("rd_pulses", n_rd, ld ? 1 : 0);
    check("wr_pulses", n_wr, ld ? 0 : 1);
    check("stall_cycles", n_stall, busy + 1 + eff);
    check("err_hold", e_hold, tmo ? 1'b1 : merr);
    check("err_pulses", n_err, (tmo || merr) ? 1 : 0);
    check("hold_data", d_hold, exp_data);
    model_data = exp_data;
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b1; validIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0;
    addrIn = 16'h0000; writeDataIn = 16'h0000; memRData = 16'h0000;
    memDone = 1'b0; memBusy = 1'b0; memErrIn = 1'b0;
    model_data = 16'h0000;
    @(negedge clk);
    #1;
    check("rst_data", memDataOut, 16'h0000);
    check("rst_outs", {memRd, memWr, errOut, stallOut}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Load, done 2 cycles after request.
    do_access(1'b1, 16'h0010, 16'h0000, 0, 2, 16'hBEEF, 1'b0);
    idle(1);
    // Store with 3 busy cycles.
    do_access(1'b0, 16'h0040, 16'h1234, 3, 1, 16'h0000, 1'b0);
    idle(1);
    // Timeout: no memDone ever.
    do_access(1'b1, 16'h0050, 16'h0000, 0, 0, 16'h0000, 1'b0);
    idle(1);
    // Done exactly in the last allowed WAIT cycle.
    do_access(1'b1, 16'h0052, 16'h0000, 1, TO, 16'hA5C3, 1'b0);
    idle(1);
    // Memory error reported with the load, then stale memDone in IDLE.
    do_access(1'b1, 16'h0060, 16'h0000, 0, 1, 16'h7E01, 1'b1);
    idle(3);

    // Read and write together: error, no request, no stall.
    validIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b1; addrIn = 16'h0070;
    memBusy = 1'b0; memDone = 1'b0;
    #1;
    check("ill_req", {memRd, memWr}, 2'b00);
    check("ill_err", errOut, 1);
    check("ill_stall", stallOut, 0);
    @(negedge clk);
    idle(1);

`ifdef MEM_ALIGN_CHECK_EN
    validIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0; addrIn = 16'h0011;
    memBusy = 1'b0; memDone = 1'b0;
    #1;
    check("mis_rd", memRd, 0);
    check("mis_err", errOut, 1);
    check("mis_stall", stallOut, 0);
    @(negedge clk);
    idle(1);
`else
    do_access(1'b1, 16'h0011, 16'h0000, 0, 1, 16'h0D0D, 1'b0);
    idle(1);
`endif

    // Randomized accesses against the reference model.
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
      a[0] = 1'b0;
`endif
      do_access(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), 16'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in WAIT, then a late memDone that must be ignored.
    validIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0; addrIn = 16'h0020;
    memBusy = 1'b0; memDone = 1'b0;
    #1;
    check("rw_issue", memRd, 1);
    @(negedge clk);
    #1;
    check("rw_wait_stall", stallOut, 1);
    rst = 1'b1;
    #1;
    check("rw_rst_err", errOut, 0);
    @(negedge clk);
    rst = 1'b0; validIn = 1'b0; memDone = 1'b1; memRData = 16'h5555; memErrIn = 1'b1;
    #1;
    check("rw_after_stall", stallOut, 0);
    check("rw_after_err", errOut, 0);
    check("rw_after_data", memDataOut, 16'h0000);
    @(negedge clk);
    memDone = 1'b0; memErrIn = 1'b0;
    #1;
    check("rw_late_data", memDataOut, 16'h0000);
    check("rw_late_err", errOut, 0);
    model_data = 16'h0000;
    @(negedge clk);
    do_access(1'b1, 16'h0022, 16'h0000, 0, 3, 16'h3C3C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
